mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 197 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: sequential 32-bit multiply/divide unit (shift-add MUL, restoring DIV/DIVU/REM/REMU).
// Optional macro MDU_DIV0_FAST_EN: divide-by-zero requests finish straight from PREP.
module mdu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        kill,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        zero
);

   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIV  = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REM  = 4'b1101;
   localparam logic [3:0] OP_REMU = 4'b1110;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   function automatic logic op_legal(input logic [3:0] o);
      case (o)
         OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: op_legal = 1'b1;
         default:                                  op_legal = 1'b0;
      endcase
   endfunction

   state_t      state_q;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] acc_q;
   logic [32:0] rem_q;
   logic [4:0]  cnt_q;
   logic        q_neg_q;
   logic        r_neg_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] result_q;
   logic        zero_q;

   logic        op_mul_d;
   logic        op_signed_d;
   logic        div_by0_d;
   logic        div0_fast_d;
   logic [32:0] mul_sum_d;
   logic [63:0] mul_acc_d;
   logic [33:0] rem_sh_d;
   logic [32:0] div_sub_d;
   logic        div_ok_d;
   logic [32:0] div_rem_d;
   logic [31:0] div_quo_d;
   logic [31:0] fix_d;

   // Datapath step values and the sign-corrected final result
   always_comb begin
      op_mul_d    = (op_q == OP_MUL);
      op_signed_d = (op_q == OP_DIV) || (op_q == OP_REM);
      div_by0_d   = (b_q == 32'd0);
`ifdef MDU_DIV0_FAST_EN
      div0_fast_d = !op_mul_d && div_by0_d;
`else
      div0_fast_d = 1'b0;
`endif
      // acc_q holds {partial product, multiplier} for MUL and the dividend/quotient in [31:0] for divide
      mul_sum_d = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
      mul_acc_d = {mul_sum_d, acc_q[31:1]};
      rem_sh_d  = {rem_q, acc_q[31]};
      div_sub_d = rem_sh_d[32:0] - {1'b0, b_q};
      div_ok_d  = (rem_sh_d >= {2'b00, b_q});
      div_rem_d = div_ok_d ? div_sub_d : rem_sh_d[32:0];
      div_quo_d = {acc_q[30:0], div_ok_d};
      case (op_q)
         OP_MUL: fix_d = acc_q[31:0];
         OP_DIV, OP_DIVU: begin
            if (div_by0_d) begin
               fix_d = 32'hFFFF_FFFF;
            end else if (q_neg_q) begin
               fix_d = 32'd0 - acc_q[31:0];
            end else begin
               fix_d = acc_q[31:0];
            end
         end
         OP_REM, OP_REMU: begin
            if (div_by0_d) begin
               fix_d = a_q;
            end else if (r_neg_q) begin
               fix_d = 32'd0 - rem_q[31:0];
            end else begin
               fix_d = rem_q[31:0];
            end
         end
         default: fix_d = 32'd0;
      endcase
   end

   // Control FSM with registered status outputs and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= 4'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         rem_q    <= 33'd0;
         cnt_q    <= 5'd0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
         zero_q   <= 1'b1;
      end else if (kill) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start && op_legal(op)) begin
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= b;
                  busy_q  <= 1'b1;
                  state_q <= S_PREP;
               end
            end
            S_PREP: begin
               q_neg_q <= op_signed_d && (a_q[31] ^ b_q[31]);
               r_neg_q <= op_signed_d && a_q[31];
               cnt_q   <= 5'd31;
               rem_q   <= 33'd0;
               if (op_mul_d) begin
                  acc_q <= {32'd0, b_q};
               end else begin
                  acc_q <= {32'd0, (op_signed_d && a_q[31]) ? 32'd0 - a_q : a_q};
                  b_q   <= (op_signed_d && b_q[31]) ? 32'd0 - b_q : b_q;
               end
               if (div0_fast_d) begin
                  result_q <= fix_d;
                  zero_q   <= (fix_d == 32'd0);
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               if (op_mul_d) begin
                  acc_q <= mul_acc_d;
               end else begin
                  acc_q <= {32'd0, div_quo_d};
                  rem_q <= div_rem_d;
               end
               if (cnt_q == 5'd0) begin
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            S_FIX: begin
               result_q <= fix_d;
               zero_q   <= (fix_d == 32'd0);
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, corner-case sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_mdu_seq;

   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIV  = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REM  = 4'b1101;
   localparam logic [3:0] OP_REMU = 4'b1110;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] last_exp;

   always #5 clk = ~clk;

   mdu_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .kill(kill), .busy(busy), .done(done), .result(result), .zero(zero)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      string       name;
   } vec_t;

   vec_t tbl[18];

   function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int sx;
      int sy;
      sx = x;
      sy = y;
      ref_model = 32'd0;
      if (o == OP_MUL) begin
         ref_model = x * y;
      end else if (o == OP_DIVU) begin
         if (y == 32'd0) ref_model = 32'hFFFF_FFFF;
         else            ref_model = x / y;
      end else if (o == OP_REMU) begin
         if (y == 32'd0) ref_model = x;
         else            ref_model = x % y;
      end else if (o == OP_DIV) begin
         if (y == 32'd0)                                         ref_model = 32'hFFFF_FFFF;
         else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)      ref_model = 32'h8000_0000;
         else                                                    ref_model = sx / sy;
      end else if (o == OP_REM) begin
         if (y == 32'd0)                                         ref_model = x;
         else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)      ref_model = 32'd0;
         else                                                    ref_model = sx % sy;
      end
   endfunction

   function automatic int exp_lat(input logic [3:0] o, input logic [31:0] y);
`ifdef MDU_DIV0_FAST_EN
      exp_lat = (o != OP_MUL && y == 32'd0) ? 2 : 35;
`else
      exp_lat = 35;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Drives a request during the current cycle (cycle 0); returns #1 into cycle 1.
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Samples done on falling edges from cycle c0 on; lat = -1 when the bound expires.
   task automatic wait_done(input int c0, output int lat);
      lat = -1;
      for (int c = c0; c <= c0 + 60; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_and_check(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] er, input logic ez, input string name);
      int lat;
      issue(o, x, y);
      wait_done(1, lat);
      chk({name, "/lat"}, lat, exp_lat(o, y));
      chk({name, "/res"}, result, er);
      chk({name, "/zero"}, {31'd0, zero}, {31'd0, ez});
      last_exp = er;
      @(posedge clk); #1;
      chk({name, "/idle_after"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int          lat;
      logic        saw_done;
      logic [3:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] e;
      logic [3:0]  ops[5];

      ops = '{OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      tbl[0]  = '{OP_MUL,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3"};
      tbl[1]  = '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_m1xm1"};
      tbl[2]  = '{OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_wrap0"};
      tbl[3]  = '{OP_MUL,  32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, "mul_small"};
      tbl[4]  = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div_-7/2"};
      tbl[5]  = '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "rem_-7/2"};
      tbl[6]  = '{OP_REMU, 32'h0000_000A, 32'h0000_0005, 32'h0000_0000, 1'b1, "remu_10/5"};
      tbl[7]  = '{OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "divu_5/0"};
      tbl[8]  = '{OP_REM,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, "rem_5/0"};
      tbl[9]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf"};
      tbl[10] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf"};
      tbl[11] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, "divu_100/7"};
      tbl[12] = '{OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, "remu_100/7"};
      tbl[13] = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7/-2"};
      tbl[14] = '{OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "rem_7/-2"};
      tbl[15] = '{OP_REM,  32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 1'b0, "rem_-8/0"};
      tbl[16] = '{OP_DIV,  32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "div_-8/0"};
      tbl[17] = '{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "divu_max/1"};

      reset = 1'b0; start = 1'b0; kill = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
      last_exp = 32'd0;
      #1 reset = 1'b1;
      #2;
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_done",   {31'd0, done},   32'd0);
      chk("rst_result", result,          32'd0);
      chk("rst_zero",   {31'd0, zero},   32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;

      // First request right after reset release, then back-to-back vectors
      for (int i = 0; i < 18; i++) begin
         run_and_check(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].z, tbl[i].name);
      end

      // Illegal op codes are ignored
      for (int k = 0; k < 2; k++) begin
         start = 1'b1; op = (k == 0) ? 4'b0000 : 4'b1111; a = 32'd1; b = 32'd1;
         @(posedge clk); #1;
         start = 1'b0;
         chk("illegal_busy", {31'd0, busy}, 32'd0);
         saw_done = 1'b0;
         repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
         end
         chk("illegal_done", {31'd0, saw_done}, 32'd0);
         chk("illegal_result", result, last_exp);
         @(posedge clk); #1;
      end

      // kill and start together in IDLE: kill wins
      kill = 1'b1; start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      kill = 1'b0; start = 1'b0;
      chk("kill_vs_start_busy", {31'd0, busy}, 32'd0);

      // Start while busy is ignored; the first operation completes untouched
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(5, lat);
      chk("busy_start/lat", lat, 35);
      chk("busy_start/res", result, 32'd14);
      last_exp = 32'd14;
      @(posedge clk); #1;

      // kill in cycle 10 of a DIV
      issue(OP_DIV, 32'd1000, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill/busy_c11", {31'd0, busy}, 32'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("kill/no_done", {31'd0, saw_done}, 32'd0);
      chk("kill/result_kept", result, last_exp);
      @(posedge clk); #1;

      // reset in cycle 20, then a request right after release
      issue(OP_MUL, 32'd3, 32'd5);
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst/busy",   {31'd0, busy}, 32'd0);
      chk("midrst/done",   {31'd0, done}, 32'd0);
      chk("midrst/result", result,        32'd0);
      chk("midrst/zero",   {31'd0, zero}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      last_exp = 32'd0;
      run_and_check(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "after_rst");

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         o = ops[$urandom_range(0, 4)];
         x = $urandom();
         case ($urandom_range(0, 5))
            0:       y = 32'd0;
            1:       y = $urandom_range(1, 15);
            2:       y = 32'hFFFF_FFFF;
            default: y = $urandom();
         endcase
         if ($urandom_range(0, 9) == 0) x = 32'h8000_0000;
         e = ref_model(o, x, y);
         run_and_check(o, x, y, e, (e == 32'd0), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
